adder_tree_pacc: RTL and testbench



---
 rtl/adder_tree_pacc.sv | 178 +++++++++++++++++
 tb/tb_adder_tree_pacc.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_pacc.sv
// adder_tree_pacc: pipelined signed adder tree with optional frame accumulator.
//
// Sums NUM_IN signed IN_W-bit lanes through LEVELS = log2(NUM_IN) registered
// pairwise-add levels, one level per clock, accepting a new vector every cycle.
// Tree sums whose vector was tagged with acc_en are accumulated ACC_LEN at a
// time; each completed frame produces a single acc_valid pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data valid this cycle
//   in_data    NUM_IN lanes, lane k at [k*IN_W +: IN_W], signed
//   acc_en     tag sampled with in_valid: vector takes part in accumulation
//   acc_clr    synchronous clear of the partial accumulator frame
//   sum_out    signed tree sum (SUM_W bits), holds between valid pulses
//   sum_valid  one-cycle pulse per input vector, LEVELS cycles after in_valid
//   acc_out    signed frame sum (ACC_W bits), holds between pulses
//   acc_valid  one-cycle pulse per completed frame
//   acc_busy   high while a partial frame is held
module adder_tree_pacc #(
  parameter int IN_W    = 12,
  parameter int NUM_IN  = 8,
  parameter int ACC_LEN = 4,
  localparam int LEVELS = $clog2(NUM_IN),
  localparam int ACC_CB = $clog2(ACC_LEN),
  localparam int SUM_W  = IN_W + LEVELS,
  localparam int ACC_W  = SUM_W + ACC_CB
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [NUM_IN*IN_W-1:0]   in_data,
  input  logic                     acc_en,
  input  logic                     acc_clr,
  output logic signed [SUM_W-1:0]  sum_out,
  output logic                     sum_valid,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     acc_valid,
  output logic                     acc_busy
);

  // Frame counter needs at least one bit even when ACC_LEN == 1.
  localparam int CNT_W = (ACC_CB > 0) ? ACC_CB : 1;

  // Level 0 is the raw input; level l holds NUM_IN>>l nodes of IN_W+l bits.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int W = IN_W + l;
    localparam int N = NUM_IN >> l;

    logic signed [W-1:0] node [N];
    logic                vld;
    logic                tag;

    if (l == 0) begin : g_src
      always_comb begin
        for (int k = 0; k < N; k++) begin
          node[k] = $signed(in_data[k*IN_W +: IN_W]);
        end
      end
      assign vld = in_valid;
      assign tag = acc_en;
    end else begin : g_add
      logic signed [W-1:0] node_d [N];
      logic signed [W-1:0] node_q [N];
      logic                vld_d, vld_q;
      logic                tag_d, tag_q;

      // Operands are sign-extended by one bit so the pair sum is exact.
      always_comb begin
        vld_d = g_lvl[l-1].vld;
        tag_d = g_lvl[l-1].tag;
        for (int j = 0; j < N; j++) begin
          node_d[j] = node_q[j];
          if (g_lvl[l-1].vld) begin
            node_d[j] = $signed({g_lvl[l-1].node[2*j][W-2],   g_lvl[l-1].node[2*j]})
                      + $signed({g_lvl[l-1].node[2*j+1][W-2], g_lvl[l-1].node[2*j+1]});
          end
        end
      end

      // ---- stage l boundary ----
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
          tag_q <= 1'b0;
        end else begin
          vld_q <= vld_d;
          tag_q <= tag_d;
        end
      end

      // Only the final level is visible as sum_out, so only it is cleared.
      if (l == LEVELS) begin : g_out_rst
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int j = 0; j < N; j++) node_q[j] <= '0;
          end else begin
            for (int j = 0; j < N; j++) node_q[j] <= node_d[j];
          end
        end
      end else begin : g_mid
        always_ff @(posedge clk) begin
          for (int j = 0; j < N; j++) node_q[j] <= node_d[j];
        end
      end

      assign node = node_q;
      assign vld  = vld_q;
      assign tag  = tag_q;
    end
  end

  logic signed [SUM_W-1:0] tree_sum;
  logic                    tree_vld;
  logic                    tree_tag;

  assign tree_sum  = g_lvl[LEVELS].node[0];
  assign tree_vld  = g_lvl[LEVELS].vld;
  assign tree_tag  = g_lvl[LEVELS].tag;
  assign sum_out   = tree_sum;
  assign sum_valid = tree_vld;

  logic signed [ACC_W-1:0] sum_ext, acc_base;
  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic signed [ACC_W-1:0] acc_out_d, acc_out_q;
  logic [CNT_W-1:0]        cnt_base, cnt_d, cnt_q;
  logic                    acc_valid_d, acc_valid_q;
  logic                    acc_busy_d, acc_busy_q;

  // acc_clr is applied before the coincident tree event, so that event
  // opens a fresh frame instead of being dropped.
  always_comb begin
    sum_ext     = ACC_W'(tree_sum);
    acc_base    = acc_clr ? '0 : acc_q;
    cnt_base    = acc_clr ? '0 : cnt_q;
    acc_d       = acc_base;
    cnt_d       = cnt_base;
    acc_out_d   = acc_out_q;
    acc_valid_d = 1'b0;
    if (tree_vld) begin
      if (!tree_tag) begin
        acc_d = '0;
        cnt_d = '0;
      end else if (cnt_base == CNT_W'(ACC_LEN - 1)) begin
        acc_out_d   = acc_base + sum_ext;
        acc_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = acc_base + sum_ext;
        cnt_d = cnt_base + CNT_W'(1);
      end
    end
    acc_busy_d = (cnt_d != '0);
  end

  // ---- accumulator stage boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      acc_busy_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      acc_out_q   <= acc_out_d;
      acc_valid_q <= acc_valid_d;
      acc_busy_q  <= acc_busy_d;
    end
  end

  assign acc_out   = acc_out_q;
  assign acc_valid = acc_valid_q;
  assign acc_busy  = acc_busy_q;

endmodule

// File: tb/tb_adder_tree_pacc.sv
// Testbench for adder_tree_pacc (IN_W=12, NUM_IN=8, ACC_LEN=4).
module tb_adder_tree_pacc;
  localparam int IN_W    = 12;
  localparam int NUM_IN  = 8;
  localparam int ACC_LEN = 4;
  localparam int SUM_W   = 15;
  localparam int ACC_W   = 17;
  localparam int NR      = 64;
  localparam int TT      = NR + 6;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic [NUM_IN*IN_W-1:0]  in_data = '0;
  logic                    acc_en = 1'b0;
  logic                    acc_clr = 1'b0;
  logic signed [SUM_W-1:0] sum_out;
  logic                    sum_valid;
  logic signed [ACC_W-1:0] acc_out;
  logic                    acc_valid;
  logic                    acc_busy;

  int errors = 0;
  int checks = 0;
  int lanes [NUM_IN];

  // random-test stimulus and expectations
  int lane_r [TT][NUM_IN];
  int rv [TT], rtg [TT], rcl [TT], rs [TT];
  int exp_sv [TT], exp_sum [TT], exp_av [TT], exp_ao [TT], exp_bz [TT];

  adder_tree_pacc #(.IN_W(IN_W), .NUM_IN(NUM_IN), .ACC_LEN(ACC_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .acc_en(acc_en), .acc_clr(acc_clr), .sum_out(sum_out), .sum_valid(sum_valid),
    .acc_out(acc_out), .acc_valid(acc_valid), .acc_busy(acc_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic en, input logic clr);
    in_valid = v;
    acc_en   = en;
    acc_clr  = clr;
    for (int k = 0; k < NUM_IN; k++) in_data[k*IN_W +: IN_W] = lanes[k][IN_W-1:0];
  endtask

  task automatic set_all(input int val);
    for (int k = 0; k < NUM_IN; k++) lanes[k] = val;
  endtask

  task automatic set_ramp();
    for (int k = 0; k < NUM_IN; k++) lanes[k] = k;
  endtask

  task automatic set_one(input int val);
    set_all(0);
    lanes[0] = val;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_all(0);
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL rst_sum_valid: got %b want 0", sum_valid); end
    checks++; if (sum_out !== '0) begin errors++; $display("FAIL rst_sum_out: got %0d want 0", sum_out); end
    checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL rst_acc_valid: got %b want 0", acc_valid); end
    checks++; if (acc_out !== '0) begin errors++; $display("FAIL rst_acc_out: got %0d want 0", acc_out); end
    checks++; if (acc_busy !== 1'b0) begin errors++; $display("FAIL rst_acc_busy: got %b want 0", acc_busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_full_scale();
    int want [3];
    want = '{16376, -16384, -4};
    for (int p = 0; p < 3; p++) begin
      if (p == 0) set_all(2047);
      else if (p == 1) set_all(-2048);
      else for (int k = 0; k < NUM_IN; k++) lanes[k] = (k % 2 == 0) ? 2047 : -2048;
      for (int c = 0; c < 5; c++) begin
        drive(c == 0, 1'b0, 1'b0);
        checks++;
        if (sum_valid !== (c == 3)) begin
          errors++; $display("FAIL fs%0d_valid c%0d: got %b want %b", p, c, sum_valid, (c == 3));
        end
        if (c >= 3) begin
          checks++;
          if (sum_out !== SUM_W'(want[p])) begin
            errors++; $display("FAIL fs%0d_sum c%0d: got %0d want %0d", p, c, sum_out, want[p]);
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_stream_bubble();
    int ev [8];
    int es [8];
    ev = '{0, 0, 0, 1, 1, 0, 1, 0};
    es = '{0, 0, 0, 28, -8, -8, 100, 100};
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: begin set_ramp();   drive(1'b1, 1'b0, 1'b0); end
        1: begin set_all(-1);  drive(1'b1, 1'b0, 1'b0); end
        3: begin set_one(100); drive(1'b1, 1'b0, 1'b0); end
        default: drive(1'b0, 1'b0, 1'b0);
      endcase
      checks++;
      if (sum_valid !== ev[c][0]) begin
        errors++; $display("FAIL stream_valid c%0d: got %b want %0d", c, sum_valid, ev[c]);
      end
      if (c >= 3) begin
        checks++;
        if (sum_out !== SUM_W'(es[c])) begin
          errors++; $display("FAIL stream_sum c%0d: got %0d want %0d", c, sum_out, es[c]);
        end
      end
      tick();
    end
  endtask

  task automatic test_frame();
    for (int c = 0; c < 9; c++) begin
      case (c)
        0: begin set_ramp();   drive(1'b1, 1'b1, 1'b0); end
        1: begin set_all(-1);  drive(1'b1, 1'b1, 1'b0); end
        2: begin set_one(100); drive(1'b1, 1'b1, 1'b0); end
        3: begin set_all(0);   drive(1'b1, 1'b1, 1'b0); end
        default: drive(1'b0, 1'b0, 1'b0);
      endcase
      checks++;
      if (acc_valid !== (c == 7)) begin
        errors++; $display("FAIL frame_valid c%0d: got %b want %b", c, acc_valid, (c == 7));
      end
      checks++;
      if (acc_busy !== (c >= 4 && c <= 6)) begin
        errors++; $display("FAIL frame_busy c%0d: got %b want %b", c, acc_busy, (c >= 4 && c <= 6));
      end
      if (c >= 7) begin
        checks++;
        if (acc_out !== ACC_W'(120)) begin
          errors++; $display("FAIL frame_acc c%0d: got %0d want 120", c, acc_out);
        end
      end
      tick();
    end
  endtask

  task automatic test_abort_clear();
    // two tagged sums then an untagged one: frame discarded
    for (int c = 0; c < 8; c++) begin
      set_one(1);
      if (c < 2) drive(1'b1, 1'b1, 1'b0);
      else if (c == 2) drive(1'b1, 1'b0, 1'b0);
      else drive(1'b0, 1'b0, 1'b0);
      checks++;
      if (acc_valid !== 1'b0) begin
        errors++; $display("FAIL abort_valid c%0d: got %b want 0", c, acc_valid);
      end
      checks++;
      if (acc_busy !== (c == 4 || c == 5)) begin
        errors++; $display("FAIL abort_busy c%0d: got %b want %b", c, acc_busy, (c == 4 || c == 5));
      end
      tick();
    end
    // 7 opens a frame, clear lands with the 5, then three 1s complete it
    for (int c = 0; c < 10; c++) begin
      case (c)
        0: set_one(7);
        1: set_one(5);
        default: set_one(1);
      endcase
      drive(c <= 4, c <= 4, c == 4);
      checks++;
      if (acc_valid !== (c == 8)) begin
        errors++; $display("FAIL clr_valid c%0d: got %b want %b", c, acc_valid, (c == 8));
      end
      if (c >= 8) begin
        checks++;
        if (acc_out !== ACC_W'(8)) begin
          errors++; $display("FAIL clr_acc c%0d: got %0d want 8", c, acc_out);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    for (int c = 0; c < 4; c++) begin
      set_one(10);
      drive(1'b1, 1'b1, 1'b0);
      if (c == 3) begin
        checks++;
        if (sum_valid !== 1'b1 || sum_out !== SUM_W'(10)) begin
          errors++; $display("FAIL mid_pre_sum: got v=%b %0d want v=1 10", sum_valid, sum_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_sum_valid: got %b want 0", sum_valid); end
        checks++; if (sum_out !== '0) begin errors++; $display("FAIL mid_rst_sum_out: got %0d want 0", sum_out); end
        checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_acc_valid: got %b want 0", acc_valid); end
        checks++; if (acc_out !== '0) begin errors++; $display("FAIL mid_rst_acc_out: got %0d want 0", acc_out); end
        checks++; if (acc_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_acc_busy: got %b want 0", acc_busy); end
      end
      tick();
    end
    rst_n = 1'b1;
    for (int c = 4; c < 13; c++) begin
      if (c == 4) set_one(33);
      else set_one(1);
      drive(c <= 7, c <= 7, 1'b0);
      checks++;
      if (sum_valid !== (c >= 7 && c <= 10)) begin
        errors++; $display("FAIL mid_post_valid c%0d: got %b want %b", c, sum_valid, (c >= 7 && c <= 10));
      end
      if (c == 7) begin
        checks++;
        if (sum_out !== SUM_W'(33)) begin
          errors++; $display("FAIL mid_post_sum c%0d: got %0d want 33", c, sum_out);
        end
      end
      if (c == 8) begin
        checks++;
        if (acc_busy !== 1'b1) begin
          errors++; $display("FAIL mid_post_busy c%0d: got %b want 1", c, acc_busy);
        end
      end
      checks++;
      if (acc_valid !== (c == 11)) begin
        errors++; $display("FAIL mid_post_acc_valid c%0d: got %b want %b", c, acc_valid, (c == 11));
      end
      if (c == 11) begin
        checks++;
        if (acc_out !== ACC_W'(36)) begin
          errors++; $display("FAIL mid_post_acc c%0d: got %0d want 36", c, acc_out);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    int hold, acc, cnt, aout, av, ev, mode;
    // stimulus
    for (int c = 0; c < TT; c++) begin
      rv[c] = 0; rtg[c] = 0; rcl[c] = 0; rs[c] = 0;
      mode = int'($urandom_range(0, 9));
      for (int k = 0; k < NUM_IN; k++) begin
        if (mode == 0) lane_r[c][k] = 2047;
        else if (mode == 1) lane_r[c][k] = -2048;
        else lane_r[c][k] = int'($urandom_range(0, 4095)) - 2048;
        rs[c] += lane_r[c][k];
      end
      if (c < NR) begin
        rv[c]  = ($urandom_range(0, 3) != 0) ? 1 : 0;
        rtg[c] = ($urandom_range(0, 7) != 0) ? 1 : 0;
        rcl[c] = ($urandom_range(0, 15) == 0) ? 1 : 0;
      end
    end
    // reference: sum appears 3 cycles after issue, frame rules one cycle later
    hold = 0; acc = 0; cnt = 0; aout = 0;
    exp_av[0] = 0; exp_ao[0] = 0; exp_bz[0] = 0;
    for (int t = 0; t < TT; t++) begin
      ev = (t >= 3) ? rv[t-3] : 0;
      exp_sv[t] = ev;
      if (ev != 0) hold = rs[t-3];
      exp_sum[t] = hold;
      av = 0;
      if (rcl[t] != 0) begin acc = 0; cnt = 0; end
      if (ev != 0) begin
        if (rtg[t-3] != 0) begin
          acc += rs[t-3];
          cnt++;
          if (cnt == ACC_LEN) begin aout = acc; av = 1; acc = 0; cnt = 0; end
        end else begin
          acc = 0; cnt = 0;
        end
      end
      if (t + 1 < TT) begin
        exp_av[t+1] = av; exp_ao[t+1] = aout; exp_bz[t+1] = (cnt != 0) ? 1 : 0;
      end
    end
    // run from a clean reset
    rst_n = 1'b0;
    set_all(0);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < TT; c++) begin
      for (int k = 0; k < NUM_IN; k++) lanes[k] = lane_r[c][k];
      drive(rv[c] != 0, rtg[c] != 0, rcl[c] != 0);
      checks++;
      if (sum_valid !== exp_sv[c][0]) begin
        errors++; $display("FAIL rnd_sum_valid c%0d: got %b want %0d", c, sum_valid, exp_sv[c]);
      end
      checks++;
      if (sum_out !== SUM_W'(exp_sum[c])) begin
        errors++; $display("FAIL rnd_sum_out c%0d: got %0d want %0d", c, sum_out, exp_sum[c]);
      end
      checks++;
      if (acc_valid !== exp_av[c][0]) begin
        errors++; $display("FAIL rnd_acc_valid c%0d: got %b want %0d", c, acc_valid, exp_av[c]);
      end
      checks++;
      if (acc_out !== ACC_W'(exp_ao[c])) begin
        errors++; $display("FAIL rnd_acc_out c%0d: got %0d want %0d", c, acc_out, exp_ao[c]);
      end
      checks++;
      if (acc_busy !== exp_bz[c][0]) begin
        errors++; $display("FAIL rnd_acc_busy c%0d: got %b want %0d", c, acc_busy, exp_bz[c]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_stream_bubble();
    test_frame();
    test_abort_clear();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
